// File: rtl/rate_spike_encoder_pkg.sv
// ---------------------------------------------------------------------------
// spike_enc_pkg
// Shared types and constants for the rate spike encoder slice.
//   enc_state_e : encoder FSM states (IDLE, RUN, DONE)
//   RATE_W_DEF  : default rate width (spike probability = rate / 2^RATE_W)
//   LEN_W_DEF   : default window-length width
//   LFSR_W / LFSR_TAPS / SEED_DEF : 16-bit Fibonacci LFSR
//   (x^16+x^14+x^13+x^11+1) used only when SPIKE_ENC_LFSR_EN is defined.
// ---------------------------------------------------------------------------
package spike_enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  localparam int RATE_W_DEF = 8;
  localparam int LEN_W_DEF  = 16;

  localparam int          LFSR_W    = 16;
  // Feedback taps at bit positions 15,13,12,10 (polynomial exponents 16,14,13,11).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_DEF  = 16'hACE1;

endpackage

// File: rtl/rate_spike_encoder_if.sv
// ---------------------------------------------------------------------------
// rate_spike_encoder_if
// Request channel into the rate spike encoder (valid/ready handshake).
//   in_valid : request valid           (master -> slave)
//   in_ready : encoder can accept      (slave  -> master)
//   in_rate  : spikes per 2^RATE_W cycles
//   in_len   : window length in cycles
// Modports: master (requester), slave (encoder).
// ---------------------------------------------------------------------------
interface rate_spike_encoder_if #(
  parameter int RATE_W = 8,
  parameter int LEN_W  = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [RATE_W-1:0] in_rate;
  logic [LEN_W-1:0]  in_len;

  modport master (
    output in_valid,
    output in_rate,
    output in_len,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_rate,
    input  in_len,
    output in_ready
  );

endinterface

// File: rtl/rate_spike_encoder_lfsr.sv
// ---------------------------------------------------------------------------
// spike_lfsr
// Free-running Fibonacci LFSR. Shifts left every clock; the new LSB is the
// XOR of the tapped bits. Loaded with SEED on reset only.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   q     : current LFSR state
// Instantiated by rate_spike_encoder only when SPIKE_ENC_LFSR_EN is defined.
// ---------------------------------------------------------------------------
module spike_lfsr
  import spike_enc_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
  parameter logic [WIDTH-1:0] SEED  = SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else begin
      q <= {q[WIDTH-2:0], ^(q & TAPS)};
    end
  end

endmodule

// File: rtl/rate_spike_encoder.sv
// ---------------------------------------------------------------------------
// rate_spike_encoder
// Rate-coding spike generator. Accepts (rate, len) requests and emits a
// registered spike train of exactly len cycles, then pulses done.
// Default coder: first-order phase accumulator (sigma-delta), giving exactly
// floor(len*rate/2^RATE_W) spikes per window.
// Build option: define SPIKE_ENC_LFSR_EN to replace the accumulator with a
// 16-bit LFSR comparator (Bernoulli-like train, same timing/handshake).
// Ports:
//   clk, rst_n  : clock / asynchronous active-low reset
//   req         : request channel (slave modport: in_valid/in_ready/in_rate/in_len)
//   abort       : terminate current window (only honoured in RUN)
//   spike_out   : registered spike train
//   busy        : window in progress
//   done        : one-cycle pulse on normal window completion
//   spike_count : spikes emitted in current/last window (saturating)
// ---------------------------------------------------------------------------
module rate_spike_encoder
  import spike_enc_pkg::*;
#(
  parameter int          RATE_W = RATE_W_DEF,
  parameter int          LEN_W  = LEN_W_DEF,
  parameter logic [15:0] SEED   = SEED_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rate_spike_encoder_if.slave  req,
  input  logic                 abort,
  output logic                 spike_out,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     spike_count
);

  enc_state_e        state;
  logic              in_ready_q;
  logic [RATE_W-1:0] rate_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_nxt;
  logic              accept;
  logic              spike_now;

  assign req.in_ready = in_ready_q;
  assign accept       = (state == IDLE) && req.in_valid && in_ready_q;
  assign cnt_nxt      = cnt_q + 1'b1;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c,
                                                input logic             inc);
    if (inc && (c != {LEN_W{1'b1}})) return c + 1'b1;
    return c;
  endfunction

`ifdef SPIKE_ENC_LFSR_EN
  logic [LFSR_W-1:0] lfsr_q;

  spike_lfsr #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR_TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign spike_now = (lfsr_q[RATE_W-1:0] < rate_q);
`else
  logic [RATE_W-1:0] acc_q;
  logic [RATE_W:0]   sum;
  // SEED only has meaning for the LFSR build.
  logic              unused_seed;

  assign unused_seed = ^SEED;
  // Carry out of the phase accumulator is the spike.
  assign sum         = {1'b0, acc_q} + {1'b0, rate_q};
  assign spike_now   = sum[RATE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= '0;
    end else if ((state == RUN) && !abort) begin
      acc_q <= sum[RATE_W-1:0];
    end
  end
`endif

  // Request latch: pure data, captured on the accept edge only.
  always_ff @(posedge clk) begin
    if (accept) begin
      rate_q <= req.in_rate;
      len_q  <= req.in_len;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      spike_out   <= 1'b0;
      spike_count <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready_q  <= 1'b0;
            spike_count <= '0;
            cnt_q       <= '0;
            if (req.in_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort wins even on the final window edge.
          if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            in_ready_q <= 1'b1;
            spike_out  <= 1'b0;
          end else begin
            spike_out   <= spike_now;
            spike_count <= sat_inc(spike_count, spike_now);
            cnt_q       <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b0;
          spike_out  <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          spike_out  <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/rate_spike_encoder.md
Name: rate_spike_encoder

Overview:
Rate-coding spike generator. It converts a rate value into a binary spike train and drives the spike_in of an lif_neuron (or a neuron array input).
- Accepts (rate, window length) requests over a valid/ready handshake.
- Emits one spike-train window of the requested length.
- Pulses done at the end of each window.
- Default mode is a deterministic phase-accumulator (first-order sigma-delta) coder, so spike counts are exact and repeatable for verification.

Parameters:
RATE_W, 8, rate width; spike probability per cycle is rate / 2^RATE_W.
LEN_W, 16, window-length width in cycles.
SEED, 16'hACE1, LFSR reset seed (used only with SPIKE_ENC_LFSR_EN).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request
in_rate  input  RATE_W  spikes per 2^RATE_W cycles
in_len  input  LEN_W  window length in cycles
abort  input  1  terminate current window
spike_out  output  1  registered spike train, to neuron spike_in
busy  output  1  window in progress
done  output  1  one-cycle pulse, window completed normally
spike_count  output  LEN_W  spikes emitted in current/last window

Behaviour:
- Reset (async assert, sync-deasserted externally): state=IDLE; spike_out=0, busy=0, done=0, spike_count=0, acc=0, in_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - An edge with in_valid&&in_ready is the accept edge E0. At E0: latch rate/len, acc<=0, spike_count<=0, cnt<=0.
  - If len==0, go to DONE with no spikes; else go to RUN.
- RUN:
  - busy=1, in_ready=0.
  - At each edge Ek (k=1..len): sum=acc+rate (RATE_W+1 bits); acc<=sum[RATE_W-1:0]; spike_out<=sum[RATE_W]; spike_count+=sum[RATE_W].
  - At edge Elen, go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, in_ready=0. This is the same cycle spike_out shows the Elen result.
  - Next edge: spike_out<=0, go to IDLE.
- Latency: first spike-window cycle is the cycle after E1, i.e. two edges after acceptance. Window spans exactly len cycles of spike_out.
- Spike count per window is exactly floor(len*rate/2^RATE_W). rate=0 gives no spikes; max rate is (2^RATE_W-1)/2^RATE_W.
- spike_count holds its value in IDLE until the next accept. It saturates at 2^LEN_W-1; this cannot be reached under default mode.
- Abort:
  - abort in RUN: next edge goes to IDLE, spike_out<=0, no done pulse, spike_count holds the partial value.
  - abort in IDLE or DONE is ignored.
  - If abort and the last RUN edge coincide, abort wins and there is no done.
- in_valid held in DONE is not accepted until IDLE (one-cycle bubble between windows).
- Inputs change while busy: ignored; latched values are used.
- Reset mid-window: everything returns to reset values immediately; no done.

Optional Feature:
Macro SPIKE_ENC_LFSR_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) replaces the accumulator.
  - Reset value is SEED. It advances every clock in all states and is not reset by accept.
  - At Ek: spike_out <= (lfsr[RATE_W-1:0] < rate). This gives a Bernoulli/Poisson-like train.
  - Spike count is stochastic; its mean is len*rate/2^RATE_W.
  - Timing and handshake are unchanged.
- Undefined: deterministic accumulator only; no LFSR logic instantiated.

Decomposition:
- Package spike_enc_pkg holds:
  - enc_state_e enum {IDLE, RUN, DONE}
  - default RATE_W/LEN_W localparams
  - LFSR tap mask constant and default SEED
- Natural sub-module: spike_lfsr (width, taps, seed; ports clk, rst_n, q). It is instantiated only under SPIKE_ENC_LFSR_EN.

Test Plan:
- Reset, hold in_valid=0 for 20 cycles -> spike_out=0, in_ready=1, busy=0, done never asserts.
- rate=128, len=10 -> spikes in window cycles 2,4,6,8,10; spike_count=5; done pulses once, coincident with cycle 10; in_ready returns the following cycle.
- rate=255, len=256 -> spike_count=255 (only cycle 1 silent); rate=0, len=50 -> 0 spikes, done after 50 cycles; len=0 -> done on the cycle after accept, no spikes.
- rate=64, len=100; assert abort at window cycle 40 -> spike_out=0 and IDLE next edge, no done, spike_count=10.
- Back-to-back: in_valid held high with rate=32/len=16 then rate=96/len=8 -> counts 2 then 3, one IDLE bubble cycle between windows; assert rst_n=0 mid-second-window -> all outputs zero immediately.
- Drive spike_out into lif_neuron spike_in with rate=255 and rate=25 (len=200) -> neuron fires for high rate; compare the neuron's spike_out count against the rate-10 periodic-stimulus result.
